mdu_issue_queue: RTL and testbench
==================================

# mdu_issue_queue

In-order issue queue that feeds the multiply/divide unit. It buffers Hi/Lo micro-op pairs from dispatch and tracks the readiness of each pair's two source physical registers through PRF writeback wakeups. It issues the head pair to the MDU only when that pair's two writeback cycles cannot collide with results already in flight. It sits between dispatch/rename and the MDU, and is the producing end of the MDU's `uopHi`/`uopLo`/PRF-read interface.

## Interface
- `DEPTH`, 4: queue entries, power of two.
- `PRF_W`, 6: physical register number width.
- `ROB_W`, 6: ROB id width.
- `WB_PORTS`, 4: number of PRF writeback wakeup ports.
- `MUL_LAT`, 3: cycles from issue to the MDU's Hi writeback for MULT/MULTU.
- `DIV_LAT`, 10: cycles from issue to the MDU's Hi writeback for DIV/DIVU. Must be greater than `MUL_LAT`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous pipeline flush.
- `enq_valid` in 1: dispatch offers a pair.
- `enq_ready` out 1: a free entry exists.
- `enq_op` in 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `enq_hi_id`, `enq_lo_id` in ROB_W each: ROB ids of the Hi and Lo uops.
- `enq_hi_dst`, `enq_lo_dst` in PRF_W each: destination physical registers.
- `enq_rs0`, `enq_rs1` in PRF_W each: source physical registers.
- `enq_rs0_rdy`, `enq_rs1_rdy` in 1 each: source ready at dispatch.
- `wb_wen` in WB_PORTS: writeback valid, one bit per port.
- `wb_rd` in WB_PORTS*PRF_W: writeback destinations, port i at bits [i*PRF_W +: PRF_W].
- `iss_valid` out 1: a pair is issued this cycle.
- `iss_op` out 2: opcode of the issued pair.
- `iss_hi_id`, `iss_lo_id` out ROB_W each: ROB ids of the issued pair.
- `iss_hi_dst`, `iss_lo_dst` out PRF_W each: destinations of the issued pair.
- `iss_rs0`, `iss_rs1` out PRF_W each: PRF read addresses. rs0 is the multiplicand or divisor; rs1 is the multiplier or dividend.

## Operation
- Storage is a circular FIFO with head/tail pointers of log2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - full = pointers differ only in the MSB.
  - empty = pointers are equal.
- `enq_ready` = !full. It does not depend on a same-cycle issue.
- Enqueue happens when `enq_valid && enq_ready && !flush`. Each source ready bit is captured as `enq_rsX_rdy` OR a match on any `wb_wen[i]` for that source's `wb_rd` in the same cycle.
- Wakeup: every valid entry sets rsX_rdy when any enabled `wb_rd` port equals rsX. Physical register 0 is treated as always ready.
- Reservation vector `res[DIV_LAT+1:0]`: `res[k]` = an MDU writeback slot k cycles from now is taken.
  - Each cycle: `res[k] <= res[k+1]`, and the top bit shifts in 0.
  - On issue with latency L (`MUL_LAT` for ops 0/1, `DIV_LAT` for ops 2/3), `res[L]` and `res[L+1]` are set. Setting is merged with the shift, so after the clock edge the bits land at L-1 and L.
- Issue rule. `iss_valid` is combinational and asserted when all of the following hold:
  - the FIFO is not empty,
  - the head has both sources ready (registered bits only; no same-cycle wakeup bypass at the head),
  - `!res[L] && !res[L+1]`,
  - `!flush`.
  On issue the head pops. All `iss_*` fields come from the head entry. When `iss_valid` is 0, all `iss_*` fields are 0.
- Flush clears head, tail and all entry-valid state in the same cycle. It overrides any simultaneous enqueue or issue. `res` is not cleared, because ops already issued still write back.
- Simultaneous enqueue and issue: both take effect, and the count is unchanged.

## Timing
- Reset (asynchronous) state:
  - pointers = 0, `res` = 0, `iss_valid` = 0, `enq_ready` = 1.
  - all `iss_*` fields = 0, all stored ready bits = 0.
- Enqueue-to-issue minimum is 1 cycle. An entry enqueued at cycle T with both sources ready can issue at T+1.
- A wakeup at cycle T makes the head eligible at T+1.
- The MDU drives Hi writeback at T+L and Lo writeback at T+L+1 for an issue at T. The reservation rule guarantees that no two issued pairs overlap in writeback cycles.
- Back-to-back MULs therefore issue at most every 2 cycles.
- A MUL issued after a DIV at T is blocked over the cycles T+DIV_LAT-MUL_LAT-1 through T+DIV_LAT-MUL_LAT+1.
- Reset asserted mid-operation drops all queued pairs immediately. Outputs return to their reset values without waiting for a clock.

## Test plan
- Reset, then enqueue a MULT (rs0=5, rs1=6, both ready, hi_id=3, lo_id=4) at cycle 0. Required: `iss_valid`=1 at cycle 1 with `iss_op`=0, `iss_rs0`=5, `iss_rs1`=6, `iss_hi_id`=3, `iss_lo_id`=4.
- Enqueue two ready MULTs at cycles 0 and 1. Required: issues at cycles 1 and 3, and `iss_valid`=0 at cycle 2.
- DIV ready at cycle 0 and MULT ready behind it. Required: DIV issues at cycle 1; MULT is blocked for cycles 7–9 and issues at cycle 10 (MUL_LAT=3, DIV_LAT=10). Checker: no cycle has two writeback reservations.
- Enqueue a pair with rs1=9 not ready. Hold 5 cycles, then pulse `wb_wen[2]` with `wb_rd[2]`=9 at cycle 6. Required: issue at cycle 7, nothing before.
- Fill all 4 entries with non-ready sources. Required: `enq_ready`=0, and a 5th `enq_valid` is not accepted. Then assert `flush`. Required: the next cycle `enq_ready`=1, `iss_valid`=0, and `res` bits from an earlier issue are still honoured.
- Assert `rst` asynchronously between clock edges while `iss_valid`=1. Required: `iss_valid` drops to 0 immediately, and queue contents are gone after release.

Source files
------------

// File: rtl/mdu_issue_queue.sv
// mdu_issue_queue: in-order issue queue in front of the multiply/divide unit.
// Buffers Hi/Lo micro-op pairs, wakes their two sources from PRF writeback, and
// issues the head pair once neither of its two writeback slots is already booked.
// Ports:
//   clk, rst (async, active-high), flush (sync)
//   enq_*   : dispatch side, enq_valid/enq_ready handshake, pair payload + source readiness
//   wb_wen/wb_rd : PRF writeback wakeup ports, port i at wb_rd[i*PRF_W +: PRF_W]
//   iss_*   : issue side toward the MDU, combinational from the head entry, zero when idle
module mdu_issue_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PRF_W    = 6,
    parameter int unsigned ROB_W    = 6,
    parameter int unsigned WB_PORTS = 4,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [1:0]                enq_op,
    input  logic [ROB_W-1:0]          enq_hi_id,
    input  logic [ROB_W-1:0]          enq_lo_id,
    input  logic [PRF_W-1:0]          enq_hi_dst,
    input  logic [PRF_W-1:0]          enq_lo_dst,
    input  logic [PRF_W-1:0]          enq_rs0,
    input  logic [PRF_W-1:0]          enq_rs1,
    input  logic                      enq_rs0_rdy,
    input  logic                      enq_rs1_rdy,
    input  logic [WB_PORTS-1:0]       wb_wen,
    input  logic [WB_PORTS*PRF_W-1:0] wb_rd,
    output logic                      iss_valid,
    output logic [1:0]                iss_op,
    output logic [ROB_W-1:0]          iss_hi_id,
    output logic [ROB_W-1:0]          iss_lo_id,
    output logic [PRF_W-1:0]          iss_hi_dst,
    output logic [PRF_W-1:0]          iss_lo_dst,
    output logic [PRF_W-1:0]          iss_rs0,
    output logic [PRF_W-1:0]          iss_rs1
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned RES_W = DIV_LAT + 2;

    typedef struct packed {
        logic [1:0]       op;
        logic [ROB_W-1:0] hi_id;
        logic [ROB_W-1:0] lo_id;
        logic [PRF_W-1:0] hi_dst;
        logic [PRF_W-1:0] lo_dst;
        logic [PRF_W-1:0] rs0;
        logic [PRF_W-1:0] rs1;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs0_rdy_q, rs0_rdy_d, rs1_rdy_q, rs1_rdy_d;
    logic [RES_W-1:0] res_q, res_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             full, empty, res_hit, enq_fire;
    entry_t           head_e;

    // Register 0 is hardwired ready; otherwise any enabled writeback port naming rs wakes it.
    function automatic logic woken(input logic [PRF_W-1:0]          rs,
                                   input logic [WB_PORTS-1:0]       wen,
                                   input logic [WB_PORTS*PRF_W-1:0] rd);
        logic hit;
        hit = (rs == '0);
        for (int i = 0; i < int'(WB_PORTS); i++) begin
            if (wen[i] && (rd[i*PRF_W +: PRF_W] == rs)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
    assign empty    = (head_q == tail_q);
    assign head_e   = ent_q[head_idx];

    // Head's Hi/Lo writebacks land at res[L] and res[L+1]; either booked means a collision.
    assign res_hit  = head_e.op[1] ? (res_q[DIV_LAT] | res_q[DIV_LAT+1])
                                   : (res_q[MUL_LAT] | res_q[MUL_LAT+1]);

    assign enq_ready = !full;
    assign enq_fire  = enq_valid && !full && !flush;
    assign iss_valid = !empty && valid_q[head_idx] && rs0_rdy_q[head_idx] &&
                       rs1_rdy_q[head_idx] && !res_hit && !flush;

    assign iss_op     = iss_valid ? head_e.op     : '0;
    assign iss_hi_id  = iss_valid ? head_e.hi_id  : '0;
    assign iss_lo_id  = iss_valid ? head_e.lo_id  : '0;
    assign iss_hi_dst = iss_valid ? head_e.hi_dst : '0;
    assign iss_lo_dst = iss_valid ? head_e.lo_dst : '0;
    assign iss_rs0    = iss_valid ? head_e.rs0    : '0;
    assign iss_rs1    = iss_valid ? head_e.rs1    : '0;

    // Next-state: wakeup, pop/book on issue, push on enqueue, flush overrides both.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        rs0_rdy_d = rs0_rdy_q;
        rs1_rdy_d = rs1_rdy_q;
        ent_d     = ent_q;
        res_d     = {1'b0, res_q[RES_W-1:1]};

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                if (woken(ent_q[i].rs0, wb_wen, wb_rd)) rs0_rdy_d[i] = 1'b1;
                if (woken(ent_q[i].rs1, wb_wen, wb_rd)) rs1_rdy_d[i] = 1'b1;
            end
        end

        if (iss_valid) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
            // Booking merges with this cycle's shift, so bits land one position lower.
            if (head_e.op[1]) begin
                res_d[DIV_LAT-1] = 1'b1;
                res_d[DIV_LAT]   = 1'b1;
            end else begin
                res_d[MUL_LAT-1] = 1'b1;
                res_d[MUL_LAT]   = 1'b1;
            end
        end

        if (enq_fire) begin
            ent_d[tail_idx].op     = enq_op;
            ent_d[tail_idx].hi_id  = enq_hi_id;
            ent_d[tail_idx].lo_id  = enq_lo_id;
            ent_d[tail_idx].hi_dst = enq_hi_dst;
            ent_d[tail_idx].lo_dst = enq_lo_dst;
            ent_d[tail_idx].rs0    = enq_rs0;
            ent_d[tail_idx].rs1    = enq_rs1;
            valid_d[tail_idx]      = 1'b1;
            rs0_rdy_d[tail_idx]    = enq_rs0_rdy | woken(enq_rs0, wb_wen, wb_rd);
            rs1_rdy_d[tail_idx]    = enq_rs1_rdy | woken(enq_rs1, wb_wen, wb_rd);
            tail_d                 = tail_q + PTR_W'(1);
        end

        // Reservations survive a flush: already-issued ops still write back.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            valid_q   <= '0;
            rs0_rdy_q <= '0;
            rs1_rdy_q <= '0;
            res_q     <= '0;
            ent_q     <= '{default: '0};
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= valid_d;
            rs0_rdy_q <= rs0_rdy_d;
            rs1_rdy_q <= rs1_rdy_d;
            res_q     <= res_d;
            ent_q     <= ent_d;
        end
    end

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Self-checking bench for mdu_issue_queue: directed scenarios plus random traffic,
// checked by a scoreboard fed from a queue/absolute-time reference model.
module tb_mdu_issue_queue;

    localparam int DEPTH    = 4;
    localparam int PRF_W    = 6;
    localparam int ROB_W    = 6;
    localparam int WB_PORTS = 4;
    localparam int MUL_LAT  = 3;
    localparam int DIV_LAT  = 10;
    localparam int MAXC     = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst, flush, enq_valid, enq_ready;
    logic [1:0]                enq_op;
    logic [ROB_W-1:0]          enq_hi_id, enq_lo_id;
    logic [PRF_W-1:0]          enq_hi_dst, enq_lo_dst, enq_rs0, enq_rs1;
    logic                      enq_rs0_rdy, enq_rs1_rdy;
    logic [WB_PORTS-1:0]       wb_wen;
    logic [WB_PORTS*PRF_W-1:0] wb_rd;
    logic                      iss_valid;
    logic [1:0]                iss_op;
    logic [ROB_W-1:0]          iss_hi_id, iss_lo_id;
    logic [PRF_W-1:0]          iss_hi_dst, iss_lo_dst, iss_rs0, iss_rs1;

    mdu_issue_queue #(
        .DEPTH(DEPTH), .PRF_W(PRF_W), .ROB_W(ROB_W), .WB_PORTS(WB_PORTS),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op),
        .enq_hi_id(enq_hi_id), .enq_lo_id(enq_lo_id),
        .enq_hi_dst(enq_hi_dst), .enq_lo_dst(enq_lo_dst),
        .enq_rs0(enq_rs0), .enq_rs1(enq_rs1),
        .enq_rs0_rdy(enq_rs0_rdy), .enq_rs1_rdy(enq_rs1_rdy),
        .wb_wen(wb_wen), .wb_rd(wb_rd),
        .iss_valid(iss_valid), .iss_op(iss_op),
        .iss_hi_id(iss_hi_id), .iss_lo_id(iss_lo_id),
        .iss_hi_dst(iss_hi_dst), .iss_lo_dst(iss_lo_dst),
        .iss_rs0(iss_rs0), .iss_rs1(iss_rs1)
    );

    typedef struct {
        logic [1:0]       op;
        logic [ROB_W-1:0] hi_id, lo_id;
        logic [PRF_W-1:0] hi_dst, lo_dst, rs0, rs1;
        bit               r0, r1;
    } ment_t;

    typedef struct {
        int               cyc;
        logic [1:0]       op;
        logic [ROB_W-1:0] hi_id, lo_id;
        logic [PRF_W-1:0] hi_dst, lo_dst, rs0, rs1;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    int    iss_log[$];
    bit    taken [MAXC];
    bit    wb_busy [MAXC];
    int    cyc;
    bit    exp_enq_rdy;
    int    checks, errors;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit wb_hit(input logic [PRF_W-1:0] rs);
        if (rs == '0) return 1'b1;
        for (int i = 0; i < WB_PORTS; i++)
            if (wb_wen[i] && wb_rd[i*PRF_W +: PRF_W] == rs) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: FIFO of pairs plus a table of booked absolute writeback cycles.
    task automatic model_step();
        int    lat;
        bit    acc;
        ment_t m;
        exp_t  e;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < MAXC; i++) taken[i] = 1'b0;
            exp_enq_rdy = 1'b1;
            return;
        end
        exp_enq_rdy = (mq.size() < DEPTH);
        acc = enq_valid && exp_enq_rdy && !flush;
        if (!flush && mq.size() > 0 && mq[0].r0 && mq[0].r1) begin
            lat = mq[0].op[1] ? DIV_LAT : MUL_LAT;
            if (!taken[cyc+lat] && !taken[cyc+lat+1]) begin
                e.cyc = cyc; e.op = mq[0].op; e.hi_id = mq[0].hi_id; e.lo_id = mq[0].lo_id;
                e.hi_dst = mq[0].hi_dst; e.lo_dst = mq[0].lo_dst;
                e.rs0 = mq[0].rs0; e.rs1 = mq[0].rs1;
                exp_q.push_back(e);
                taken[cyc+lat]   = 1'b1;
                taken[cyc+lat+1] = 1'b1;
                void'(mq.pop_front());
            end
        end
        foreach (mq[i]) begin
            if (wb_hit(mq[i].rs0)) mq[i].r0 = 1'b1;
            if (wb_hit(mq[i].rs1)) mq[i].r1 = 1'b1;
        end
        if (acc) begin
            m.op = enq_op; m.hi_id = enq_hi_id; m.lo_id = enq_lo_id;
            m.hi_dst = enq_hi_dst; m.lo_dst = enq_lo_dst;
            m.rs0 = enq_rs0; m.rs1 = enq_rs1;
            m.r0 = enq_rs0_rdy || wb_hit(enq_rs0);
            m.r1 = enq_rs1_rdy || wb_hit(enq_rs1);
            mq.push_back(m);
        end
        if (flush) mq.delete();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        enq_valid = 1'b0;
        flush     = 1'b0;
        wb_wen    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic enq(input logic [1:0] op, input int hi, input int lo,
                       input int rs0, input int rs1, input bit r0, input bit r1);
        enq_valid   = 1'b1;
        enq_op      = op;
        enq_hi_id   = ROB_W'(hi);
        enq_lo_id   = ROB_W'(lo);
        enq_hi_dst  = PRF_W'(hi + 32);
        enq_lo_dst  = PRF_W'(lo + 32);
        enq_rs0     = PRF_W'(rs0);
        enq_rs1     = PRF_W'(rs1);
        enq_rs0_rdy = r0;
        enq_rs1_rdy = r1;
    endtask

    task automatic check_log(input string name, input int n, input int a, input int b);
        chk(iss_log.size() == n, {name, "_count"}, iss_log.size(), n);
        if (n > 0 && iss_log.size() > 0) chk(iss_log[0] == a, {name, "_cycle0"}, iss_log[0], a);
        if (n > 1 && iss_log.size() > 1) chk(iss_log[1] == b, {name, "_cycle1"}, iss_log[1], b);
    endtask

    // Monitor: compares DUT issue activity against the scoreboard every cycle.
    initial begin
        exp_t e;
        bit   exp_now;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < MAXC; i++) wb_busy[i] = 1'b0;
                continue;
            end
            chk(enq_ready == exp_enq_rdy, "enq_ready", enq_ready, exp_enq_rdy);
            exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk(iss_valid == exp_now, "iss_valid", iss_valid, exp_now);
            if (exp_now) begin
                e = exp_q.pop_front();
                if (iss_valid) begin
                    checks++;
                    if (iss_op != e.op || iss_hi_id != e.hi_id || iss_lo_id != e.lo_id ||
                        iss_hi_dst != e.hi_dst || iss_lo_dst != e.lo_dst ||
                        iss_rs0 != e.rs0 || iss_rs1 != e.rs1) begin
                        errors++;
                        $display("FAIL iss_fields: actual op=%0d hi=%0d lo=%0d hd=%0d ld=%0d rs0=%0d rs1=%0d, required op=%0d hi=%0d lo=%0d hd=%0d ld=%0d rs0=%0d rs1=%0d (cycle %0d)",
                                 iss_op, iss_hi_id, iss_lo_id, iss_hi_dst, iss_lo_dst, iss_rs0, iss_rs1,
                                 e.op, e.hi_id, e.lo_id, e.hi_dst, e.lo_dst, e.rs0, e.rs1, cyc);
                    end
                end
            end
            if (iss_valid) begin
                iss_log.push_back(cyc);
                lat = iss_op[1] ? DIV_LAT : MUL_LAT;
                chk(!wb_busy[cyc+lat] && !wb_busy[cyc+lat+1], "wb_overlap",
                    {wb_busy[cyc+lat], wb_busy[cyc+lat+1]}, 0);
                wb_busy[cyc+lat]   = 1'b1;
                wb_busy[cyc+lat+1] = 1'b1;
            end else begin
                chk({iss_op, iss_hi_id, iss_lo_id, iss_hi_dst, iss_lo_dst, iss_rs0, iss_rs1} == '0,
                    "iss_idle_zero", iss_rs0, 0);
            end
        end
    end

    initial begin
        int c0;
        checks = 0; errors = 0; cyc = 0; exp_enq_rdy = 1'b1;
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0;
        enq_op = '0; enq_hi_id = '0; enq_lo_id = '0; enq_hi_dst = '0; enq_lo_dst = '0;
        enq_rs0 = '0; enq_rs1 = '0; enq_rs0_rdy = 1'b0; enq_rs1_rdy = 1'b0;
        wb_wen = '0; wb_rd = '0;
        idle(3);
        chk(iss_valid == 1'b0, "reset_iss_valid", iss_valid, 0);
        chk(enq_ready == 1'b1, "reset_enq_ready", enq_ready, 1);
        chk({iss_op, iss_hi_id, iss_lo_id, iss_rs0, iss_rs1} == '0, "reset_iss_fields", iss_rs0, 0);
        rst = 1'b0;
        idle(2);

        // Single ready MULT issues one cycle after enqueue.
        iss_log.delete(); c0 = cyc;
        enq(2'd0, 3, 4, 5, 6, 1, 1); tick();
        idle(8);
        check_log("single_mult", 1, c0 + 1, 0);

        // Back-to-back MULTs are spaced by two cycles.
        iss_log.delete(); c0 = cyc;
        enq(2'd0, 1, 2, 7, 8, 1, 1); tick();
        enq(2'd1, 5, 6, 9, 10, 1, 1); tick();
        idle(10);
        check_log("mult_pair", 2, c0 + 1, c0 + 3);

        // MULT woken after a DIV waits out the DIV's writeback window.
        iss_log.delete(); c0 = cyc;
        enq(2'd2, 10, 11, 7, 8, 1, 1); tick();
        enq(2'd0, 12, 13, 11, 20, 1, 0); tick();
        idle(4);
        wb_wen[0] = 1'b1; wb_rd[0 +: PRF_W] = PRF_W'(20); tick();
        idle(12);
        check_log("div_then_mult", 2, c0 + 1, c0 + 10);

        // Late wakeup through port 2.
        iss_log.delete(); c0 = cyc;
        enq(2'd1, 14, 15, 12, 9, 1, 0); tick();
        idle(5);
        wb_wen[2] = 1'b1; wb_rd[2*PRF_W +: PRF_W] = PRF_W'(9); tick();
        idle(12);
        check_log("wakeup", 1, c0 + 7, 0);

        // Fill, reject a 5th, flush, and honour the earlier DIV's reservation.
        iss_log.delete(); c0 = cyc;
        enq(2'd3, 16, 17, 1, 2, 1, 1); tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk(enq_ready == 1'b0, "full_enq_ready", enq_ready, 0);
            enq(2'd0, 20 + k, 25 + k, 30, 31, 0, 0); tick();
        end
        flush = 1'b1; tick();
        chk(enq_ready == 1'b1, "post_flush_enq_ready", enq_ready, 1);
        chk(iss_valid == 1'b0, "post_flush_iss_valid", iss_valid, 0);
        enq(2'd0, 40, 41, 3, 4, 1, 1); tick();
        idle(12);
        check_log("flush_res", 2, c0 + 1, c0 + 10);

        // Asynchronous reset while a pair is being issued.
        iss_log.delete(); c0 = cyc;
        enq(2'd0, 50, 51, 5, 6, 1, 1); tick();
        enq(2'd0, 52, 53, 7, 8, 1, 1); tick();
        tick();
        chk(iss_valid == 1'b1, "pre_reset_iss_valid", iss_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk(iss_valid == 1'b0, "async_reset_iss_valid", iss_valid, 0);
        chk(enq_ready == 1'b1, "async_reset_enq_ready", enq_ready, 1);
        exp_enq_rdy = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(10);
        check_log("async_reset", 1, c0 + 1, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(99) < 60) begin
                enq(2'($urandom_range(3)), int'($urandom_range(63)), int'($urandom_range(63)),
                    int'($urandom_range(15)), int'($urandom_range(15)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
                enq_hi_dst = PRF_W'($urandom);
                enq_lo_dst = PRF_W'($urandom);
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if ($urandom_range(99) < 25) begin
                    wb_wen[p] = 1'b1;
                    wb_rd[p*PRF_W +: PRF_W] = PRF_W'($urandom_range(15));
                end
            end
            flush = ($urandom_range(99) < 2);
            tick();
        end
        idle(15);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
